// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: execute-stage multiply/divide sequencer and HI/LO owner.
// A mul/div op holds E while BUSY. The result is committed to HI/LO on
// the edge that leaves DONE with no external stall. MTHI/MTLO write
// directly while the block is idle.
module muldiv_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_validE,
  input  logic [2:0]  opE,
  input  logic [31:0] src_aE,
  input  logic [31:0] src_bE,
  input  logic [1:0]  hilo_weE,
  input  logic [31:0] hilo_wdataE,
  input  logic        flushE,
  input  logic        stall_extE,
  output logic        stallE,
  output logic        busyE,
  output logic [63:0] hilo_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [5:0]  cnt_r;
  logic [2:0]  op_r;
  logic [31:0] a_r;          // multiplicand, or dividend magnitude / quotient shift register
  logic [31:0] b_r;          // multiplier, or divisor magnitude
  logic [31:0] rem_r;        // partial remainder
  logic        neg_q_r;
  logic        neg_r_r;
  logic        commit_ok_r;  // cleared for divide by zero
  logic [63:0] result_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic [63:0] a_ext_s, b_ext_s, prod_s;
  logic [32:0] trial_s, diff_s;
  logic        qbit_s;
  logic [31:0] quo_next_s, rem_next_s, quo_fix_s, rem_fix_s;
  logic [63:0] commit_val_s;

  // Divide-class opcodes are 2 (DIV) and 3 (DIVU).
  function automatic logic is_div(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

  // Even opcodes are the signed variants.
  function automatic logic is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

  // Absolute value of an operand when the op is signed.
  function automatic logic [31:0] mag(input logic sgn, input logic [31:0] x);
    return (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

  assign stallE   = ((state_r == S_IDLE) && op_validE && !flushE) || (state_r == S_BUSY);
  assign busyE    = (state_r == S_BUSY);
  assign hilo_out = {hi_r, lo_r};

  // Product, one restoring-division step and the commit value, all from latched state.
  always_comb begin
    a_ext_s = is_signed(op_r) ? {{32{a_r[31]}}, a_r} : {32'd0, a_r};
    b_ext_s = is_signed(op_r) ? {{32{b_r[31]}}, b_r} : {32'd0, b_r};
    prod_s  = a_ext_s * b_ext_s;

    trial_s    = {rem_r, a_r[31]};
    diff_s     = trial_s - {1'b0, b_r};
    qbit_s     = ~diff_s[32];
    rem_next_s = qbit_s ? diff_s[31:0] : trial_s[31:0];
    quo_next_s = {a_r[30:0], qbit_s};
    quo_fix_s  = neg_q_r ? (32'd0 - quo_next_s) : quo_next_s;
    rem_fix_s  = neg_r_r ? (32'd0 - rem_next_s) : rem_next_s;

    case (op_r)
      3'd4, 3'd5: commit_val_s = {hi_r, lo_r} + result_r;
      3'd6, 3'd7: commit_val_s = {hi_r, lo_r} - result_r;
      default:    commit_val_s = result_r;
    endcase
  end

  // Sequencer FSM, operand/divider datapath and HI/LO registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= 6'd0;
      op_r        <= 3'd0;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      rem_r       <= 32'd0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      commit_ok_r <= 1'b0;
      result_r    <= 64'd0;
      hi_r        <= 32'd0;
      lo_r        <= 32'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (!flushE && op_validE) begin
            op_r    <= opE;
            rem_r   <= 32'd0;
            state_r <= S_BUSY;
            if (is_div(opE)) begin
              a_r         <= mag(is_signed(opE), src_aE);
              b_r         <= mag(is_signed(opE), src_bE);
              neg_q_r     <= is_signed(opE) & (src_aE[31] ^ src_bE[31]);
              neg_r_r     <= is_signed(opE) & src_aE[31];
              commit_ok_r <= (src_bE != 32'd0);
              cnt_r       <= 6'd32;
            end else begin
              a_r         <= src_aE;
              b_r         <= src_bE;
              neg_q_r     <= 1'b0;
              neg_r_r     <= 1'b0;
              commit_ok_r <= 1'b1;
              cnt_r       <= 6'(MUL_LAT);
            end
          end else if (!flushE) begin
            if (hilo_weE[1]) hi_r <= hilo_wdataE;
            if (hilo_weE[0]) lo_r <= hilo_wdataE;
          end
        end
        S_BUSY: begin
          if (flushE) begin
            state_r <= S_IDLE;
            cnt_r   <= 6'd0;
          end else begin
            cnt_r <= cnt_r - 6'd1;
            if (is_div(op_r)) begin
              a_r   <= quo_next_s;
              rem_r <= rem_next_s;
            end
            if (cnt_r == 6'd1) begin
              result_r <= is_div(op_r) ? {rem_fix_s, quo_fix_s} : prod_s;
              state_r  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // op_validE is still the same instruction here, so it never restarts.
          if (flushE) begin
            state_r <= S_IDLE;
          end else if (!stall_extE) begin
            if (commit_ok_r) begin
              hi_r <= commit_val_s[63:32];
              lo_r <= commit_val_s[31:0];
            end
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (MUL_LAT = 3).
module tb_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        op_validE;
  logic [2:0]  opE;
  logic [31:0] src_aE, src_bE;
  logic [1:0]  hilo_weE;
  logic [31:0] hilo_wdataE;
  logic        flushE, stall_extE;
  logic        stallE, busyE;
  logic [63:0] hilo_out;

  int checks = 0;
  int failures = 0;
  int stalls;

  muldiv_ctrl #(.MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .op_validE(op_validE), .opE(opE),
    .src_aE(src_aE), .src_bE(src_bE), .hilo_weE(hilo_weE),
    .hilo_wdataE(hilo_wdataE), .flushE(flushE), .stall_extE(stall_extE),
    .stallE(stallE), .busyE(busyE), .hilo_out(hilo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op with stall_extE low; returns the number of stallE cycles.
  // Entered and left at 1 time unit after a rising edge.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    n = 0;
    opE = op; src_aE = a; src_bE = b; op_validE = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (stallE) n++;
      else if (n > 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    op_validE = 1'b0;
  endtask

  task automatic mt(input logic [1:0] we, input logic [31:0] d);
    hilo_weE = we; hilo_wdataE = d;
    @(posedge clk); #1;
    hilo_weE = 2'b00;
  endtask

  initial begin
    rst = 1'b0; op_validE = 1'b0; opE = 3'd0; src_aE = 32'd0; src_bE = 32'd0;
    hilo_weE = 2'b00; hilo_wdataE = 32'd0; flushE = 1'b0; stall_extE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hilo", hilo_out, 64'd0);
    check("rst_busy", {63'd0, busyE}, 64'd0);
    check("rst_stall", {63'd0, stallE}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // MULT -3 * 5
    do_op(3'd0, 32'hFFFF_FFFD, 32'd5, stalls);
    check("mult_stalls", 64'(stalls), 64'd4);
    check("mult_hilo", hilo_out, 64'hFFFF_FFFF_FFFF_FFF1);

    // DIV -7 / 2 and DIVU of the same bits
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, stalls);
    check("div_stalls", 64'(stalls), 64'd33);
    check("div_hilo", hilo_out, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2, stalls);
    check("divu_hilo", hilo_out, 64'h0000_0001_7FFF_FFFC);

    // Accumulate
    mt(2'b01, 32'hFFFF_FFFF);
    mt(2'b10, 32'h0000_0000);
    check("mt_hilo", hilo_out, 64'h0000_0000_FFFF_FFFF);
    do_op(3'd5, 32'd1, 32'd1, stalls);
    check("maddu_hilo", hilo_out, 64'h0000_0001_0000_0000);
    do_op(3'd6, 32'd2, 32'd3, stalls);
    check("msub_stalls", 64'(stalls), 64'd4);
    check("msub_hilo", hilo_out, 64'h0000_0000_FFFF_FFFA);

    // Divide by zero leaves HI/LO alone
    mt(2'b10, 32'h1111_1111);
    mt(2'b01, 32'h2222_2222);
    do_op(3'd3, 32'd100, 32'd0, stalls);
    check("div0_stalls", 64'(stalls), 64'd33);
    check("div0_hilo", hilo_out, 64'h1111_1111_2222_2222);

    // Boundary products and quotient
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, stalls);
    check("div_ovf_hilo", hilo_out, 64'h0000_0000_8000_0000);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, stalls);
    check("multu_max", hilo_out, 64'hFFFF_FFFE_0000_0001);
    do_op(3'd0, 32'h8000_0000, 32'h8000_0000, stalls);
    check("mult_minmin", hilo_out, 64'h4000_0000_0000_0000);

    // Flush in the 10th BUSY cycle of a DIV
    opE = 3'd2; src_aE = 32'd100; src_bE = 32'd7; op_validE = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("flush_busy10", {63'd0, busyE}, 64'd1);
    flushE = 1'b1;
    @(posedge clk); #1;
    flushE = 1'b0; op_validE = 1'b0;
    #1;
    check("flush_stall", {63'd0, stallE}, 64'd0);
    check("flush_busy", {63'd0, busyE}, 64'd0);
    check("flush_hilo", hilo_out, 64'h4000_0000_0000_0000);
    @(posedge clk); #1;
    do_op(3'd0, 32'd6, 32'd7, stalls);
    check("post_flush_stalls", 64'(stalls), 64'd4);
    check("post_flush_hilo", hilo_out, 64'd42);

    // MADDU held in DONE by stall_extE; must commit once
    opE = 3'd5; src_aE = 32'd3; src_bE = 32'd4; op_validE = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!stallE) break;
      @(posedge clk); #1;
    end
    stall_extE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("ext_busy", {63'd0, busyE}, 64'd0);
      check("ext_hilo_hold", hilo_out, 64'd42);
    end
    stall_extE = 1'b0;
    @(posedge clk); #1;
    op_validE = 1'b0;
    check("ext_commit", hilo_out, 64'd54);
    repeat (3) @(posedge clk);
    #1;
    check("ext_once", hilo_out, 64'd54);
    check("ext_idle", {63'd0, busyE}, 64'd0);

    // Reset during BUSY
    opE = 3'd3; src_aE = 32'd100; src_bE = 32'd7; op_validE = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rstmid_busy", {63'd0, busyE}, 64'd1);
    rst = 1'b0; op_validE = 1'b0;
    @(posedge clk); #1;
    check("rstmid_hilo", hilo_out, 64'd0);
    check("rstmid_busy0", {63'd0, busyE}, 64'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rstmid_nocommit", hilo_out, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
